// File: rtl/ebr_port_arbiter.sv
// ebr_port_arbiter: round-robin write/read arbiter and clear sequencer for one 256x16 EBR.
// Latency: the write is committed at the edge that ends the grant cycle; read data arrives one cycle after the grant.
// Backpressure: requests are levels held until granted; nothing is granted while clearing (busy).
// Optional feature macro: EBR_ARB_BYPASS_EN (forwards same-cycle same-address write data into the read result).
module ebr_port_arbiter #(
  parameter int NREQ       = 4,
  parameter bit CLR_ON_RST = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      wr_req,
  input  logic [NREQ*8-1:0]    wr_addr,
  input  logic [NREQ*16-1:0]   wr_data,
  input  logic [NREQ*16-1:0]   wr_mask,
  output logic [NREQ-1:0]      wr_gnt,
  input  logic [NREQ-1:0]      rd_req,
  input  logic [NREQ*8-1:0]    rd_addr,
  output logic [NREQ-1:0]      rd_gnt,
  output logic [NREQ-1:0]      rd_vld,
  output logic [15:0]          rd_data,
  input  logic                 clr_req,
  output logic                 busy,
  output logic                 ram_we,
  output logic [7:0]           ram_waddr,
  output logic [15:0]          ram_wdata,
  output logic [15:0]          ram_wmask,
  output logic                 ram_re,
  output logic [7:0]           ram_raddr,
  input  logic [15:0]          ram_rdata
);

  localparam int PW = (NREQ <= 2) ? 1 : (NREQ <= 4) ? 2 : 3;

  typedef enum logic {S_CLEAR = 1'b0, S_RUN = 1'b1} state_t;
  localparam state_t RST_STATE = CLR_ON_RST ? S_CLEAR : S_RUN;

  // First requester at or after ptr (wrapping); MSB of the result flags that one was found.
  function automatic logic [PW:0] rr_pick(input logic [NREQ-1:0] req, input logic [PW-1:0] ptr);
    logic [PW:0] res;
    int          j;
    res = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (req[j[PW-1:0]]) res = {1'b1, j[PW-1:0]};
    end
    return res;
  endfunction

  state_t          r_state;
  state_t          w_state_nxt;
  logic [7:0]      r_cc;
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [NREQ-1:0] r_rd_vld;

  logic [PW:0]     w_wr_pick;
  logic [PW:0]     w_rd_pick;
  logic            w_wr_any;
  logic            w_rd_any;
  logic [PW-1:0]   w_wr_idx;
  logic [PW-1:0]   w_rd_idx;
  logic            w_run;

  assign w_wr_pick = rr_pick(wr_req, r_wr_ptr);
  assign w_rd_pick = rr_pick(rd_req, r_rd_ptr);
  assign w_wr_any  = w_wr_pick[PW];
  assign w_rd_any  = rd_pick_any(w_rd_pick);
  assign w_wr_idx  = w_wr_pick[PW-1:0];
  assign w_rd_idx  = w_rd_pick[PW-1:0];
  assign w_run     = (r_state == S_RUN);
  assign rd_vld    = r_rd_vld;

  function automatic logic rd_pick_any(input logic [PW:0] pick);
    return pick[PW];
  endfunction

  // State register: clear-after-reset or straight to traffic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= RST_STATE;
    else        r_state <= w_state_nxt;
  end

  // Next state: the clear ends after address 255 is written; clr_req only matters in RUN.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_CLEAR: if (r_cc == 8'hFF) w_state_nxt = S_RUN;
      S_RUN:   if (clr_req)       w_state_nxt = S_CLEAR;
      default: w_state_nxt = RST_STATE;
    endcase
  end

  // Outputs: the clear sweep owns the write port; in RUN the winners drive the EBR directly.
  always_comb begin
    busy      = 1'b0;
    wr_gnt    = '0;
    rd_gnt    = '0;
    ram_we    = 1'b0;
    ram_waddr = wr_addr[8*w_wr_idx +: 8];
    ram_wdata = wr_data[16*w_wr_idx +: 16];
    ram_wmask = wr_mask[16*w_wr_idx +: 16];
    ram_re    = 1'b0;
    ram_raddr = rd_addr[8*w_rd_idx +: 8];
    case (r_state)
      S_CLEAR: begin
        busy      = 1'b1;
        ram_we    = 1'b1;
        ram_waddr = r_cc;
        ram_wdata = 16'h0000;
        ram_wmask = 16'hFFFF;
      end
      S_RUN: begin
        wr_gnt[w_wr_idx] = w_wr_any;
        rd_gnt[w_rd_idx] = w_rd_any;
        ram_we           = w_wr_any;
        ram_re           = w_rd_any;
      end
      default: busy = 1'b0;
    endcase
  end

  // Clear counter walks 0..255 while clearing and sits at 0 otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 r_cc <= '0;
    else if (r_state == S_CLEAR) r_cc <= r_cc + 8'd1;
    else                        r_cc <= '0;
  end

  // Round-robin pointers move past the winner; they hold when nothing is granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_run && w_wr_any) r_wr_ptr <= (w_wr_idx == PW'(NREQ - 1)) ? '0 : w_wr_idx + 1'b1;
      if (w_run && w_rd_any) r_rd_ptr <= (w_rd_idx == PW'(NREQ - 1)) ? '0 : w_rd_idx + 1'b1;
    end
  end

  // Read valid follows the read grant by one cycle, even across a clear request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rd_vld <= '0;
    else        r_rd_vld <= rd_gnt;
  end

`ifdef EBR_ARB_BYPASS_EN
  logic        r_byp_vld;
  logic [15:0] r_byp_data;
  logic [15:0] r_byp_mask;

  // Capture a write that collides with the concurrent read so the read sees post-write data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_byp_vld  <= 1'b0;
      r_byp_data <= '0;
      r_byp_mask <= '0;
    end else begin
      r_byp_vld  <= ram_we & ram_re & (ram_waddr == ram_raddr);
      r_byp_data <= ram_wdata;
      r_byp_mask <= ram_wmask;
    end
  end

  assign rd_data = r_byp_vld ? ((ram_rdata & ~r_byp_mask) | (r_byp_data & r_byp_mask)) : ram_rdata;
`else
  assign rd_data = ram_rdata;
`endif

endmodule
